// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (adds the HALT state).
package fetch_pkg;

    localparam int INSTR_W   = 32;
    localparam int XLEN      = 32;
    localparam int BUF_DEPTH = 2;

    // Occupancy value at which the buffer is full.
    localparam logic [1:0] BUF_FULL = 2'd2;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [1:0] {
        ST_ISSUE    = 2'd0,
        ST_WAIT_RSP = 2'd1,
        ST_HALT     = 2'd2
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        ST_ISSUE    = 2'd0,
        ST_WAIT_RSP = 2'd1
    } fetch_state_t;
`endif

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    // Clears the byte offset so the address names a whole 32-bit word.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: two-entry instruction FIFO with push, pop and flush.
// The head entry is always visible; count says whether it is meaningful.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [BUF_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    // A pop of an empty buffer or a push into a full one is ignored.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && (count != BUF_FULL);

    assign head = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, single-outstanding instruction memory
// requests, a 2-entry instruction buffer and the decode handshake.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirect
// detection with a HALT state); without it target bits [1:0] are cleared.
//
// Handshakes: a transfer happens in a cycle where the producer's valid and
// the consumer's ready/grant are both high at the rising edge. Once raised,
// imem_req_o and imem_addr_o hold until imem_gnt_i (a redirect may replace
// them); instr_valid_o/instr_o/instr_pc_o hold until instr_ready_i (a
// redirect may flush them). Valid never depends combinationally on ready.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req_o,
    output logic [XLEN-1:0]    imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [XLEN-1:0]    instr_pc_o,
    input  logic               instr_ready_i,
    output logic               fetch_misalign_o,
    output fetch_state_t       state_dbg
);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_nxt;
    logic [XLEN-1:0]  req_pc;
    logic [XLEN-1:0]  req_pc_nxt;
    logic             kill;
    logic             kill_nxt;
    logic             run;

    logic             fetch_req;
    logic             granted;
    logic             outstanding;
    logic             rsp;
    logic             still_out;
    logic             buf_push;
    logic             buf_pop;
    logic [1:0]       count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

`ifdef FETCH_MISALIGN_CHK_EN
    logic             tgt_misaligned;
    logic             misalign_q;

    assign tgt_misaligned   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign fetch_misalign_o = misalign_q;

    // One-cycle pulse following a misaligned redirect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= tgt_misaligned;
        end
    end
`else
    logic             unused_tgt_bits;

    assign unused_tgt_bits  = ^redirect_pc_i[1:0];
    assign fetch_misalign_o = 1'b0;
`endif

    // A request is in flight while waiting, or while a killed one is pending
    // (kill can only be set when a response is still owed).
    assign outstanding = (state == ST_WAIT_RSP) || kill;
    assign fetch_req   = run && (state == ST_ISSUE) && (count != BUF_FULL);
    assign granted     = fetch_req && imem_gnt_i;
    assign rsp         = outstanding && imem_rvalid_i;
    // After this edge, will a response still be owed to us?
    assign still_out   = (outstanding && !imem_rvalid_i) || granted;
    assign buf_push    = rsp && !kill && !redirect_i;
    assign buf_pop     = instr_valid_o && instr_ready_i;
    assign push_entry  = '{instr: imem_rdata_i, pc: req_pc};

    assign imem_req_o    = fetch_req;
    assign imem_addr_o   = pc;
    assign instr_valid_o = (count != 2'd0);
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign state_dbg     = state;

    fetch_buf u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (buf_push),
        .push_entry (push_entry),
        .pop        (buf_pop),
        .flush      (redirect_i),
        .head       (head),
        .count      (count)
    );

    // State, PC and kill registers; run holds off requests during reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ST_ISSUE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            kill   <= 1'b0;
            run    <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            req_pc <= req_pc_nxt;
            kill   <= kill_nxt;
            run    <= 1'b1;
        end
    end

    // Next-state logic: normal fetch progress first, redirect overrides last.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        req_pc_nxt = req_pc;
        kill_nxt   = kill;

        case (state)
            ST_ISSUE: begin
                if (granted) begin
                    req_pc_nxt = pc;
                    pc_nxt     = pc + PC_STEP;
                    state_nxt  = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (imem_rvalid_i) begin
                    kill_nxt  = 1'b0;
                    state_nxt = ST_ISSUE;
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            ST_HALT: begin
                // Still absorb a killed response so kill does not linger.
                if (rsp) begin
                    kill_nxt = 1'b0;
                end
            end
`endif
            default: begin
                state_nxt = ST_ISSUE;
            end
        endcase

        if (redirect_i) begin
            kill_nxt  = still_out;
            state_nxt = still_out ? ST_WAIT_RSP : ST_ISSUE;
            pc_nxt    = align_word(redirect_pc_i);
`ifdef FETCH_MISALIGN_CHK_EN
            if (tgt_misaligned) begin
                pc_nxt    = redirect_pc_i;
                state_nxt = ST_HALT;
            end
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch with a behavioural model
// of the delivered instruction stream and of the request/occupancy rules.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               imem_req_o;
    logic [31:0]        imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i;
    logic [31:0]        imem_rdata_i;
    logic               redirect_i;
    logic [31:0]        redirect_pc_i;
    logic               instr_valid_o;
    logic [31:0]        instr_o;
    logic [31:0]        instr_pc_o;
    logic               instr_ready_i;
    logic               fetch_misalign_o;
    fetch_state_t       state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: upcoming delivered PCs, buffer occupancy, memory side.
    logic [31:0] exp_q[$];
    int          occ;
    bit          pending;
    int          wait_cnt;
    int          pend_epoch;
    int          epoch = 0;
    logic [31:0] pend_addr;
    logic [31:0] exp_req_addr;
    bit          halted;
    bit          exp_mis;

    int ready_pct = 100;
    int gnt_pct   = 100;
    int min_delay = 0;
    int max_delay = 0;
    int cyc       = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_ready_i    (instr_ready_i),
        .fetch_misalign_o (fetch_misalign_o),
        .state_dbg        (state_dbg)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
    endfunction

    task automatic model_restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic model_init();
        pending      = 0;
        wait_cnt     = 0;
        occ          = 0;
        halted       = 0;
        exp_mis      = 0;
        epoch        = epoch + 1;
        exp_req_addr = 32'h0;
        model_restart(32'h0);
    endtask

    task automatic drive_idle();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;
    endtask

    // One clock of randomized memory/decode behaviour, checks, model update.
    task automatic cycle(input bit redir, input logic [31:0] tgt);
        bit rv, g, rdy, pop, exp_req_v, exp_valid;
        @(posedge clk);
        #1;
        rdy = ($urandom_range(99) < ready_pct);
        g   = imem_req_o && ($urandom_range(99) < gnt_pct);
        rv  = 1'b0;
        if (pending) begin
            if (wait_cnt == 0) rv = 1'b1;
            else wait_cnt--;
        end
        instr_ready_i = rdy;
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? word_of(pend_addr) : $urandom();
        redirect_i    = redir;
        redirect_pc_i = tgt;
        @(negedge clk);
        cyc++;

        exp_req_v = !halted && !pending && (occ < 2);
        exp_valid = (occ != 0);
        checks++;
        if (imem_req_o !== exp_req_v) begin
            errors++;
            $display("FAIL req: got %0b expected %0b (cycle %0d)", imem_req_o, exp_req_v, cyc);
        end
        if (exp_req_v) begin
            checks++;
            if (imem_addr_o !== exp_req_addr) begin
                errors++;
                $display("FAIL addr: got %h expected %h (cycle %0d)", imem_addr_o, exp_req_addr, cyc);
            end
        end
        checks++;
        if (instr_valid_o !== exp_valid) begin
            errors++;
            $display("FAIL valid: got %0b expected %0b (cycle %0d)", instr_valid_o, exp_valid, cyc);
        end
        if (exp_valid) begin
            checks++;
            if (instr_pc_o !== exp_q[0]) begin
                errors++;
                $display("FAIL instr_pc: got %h expected %h (cycle %0d)", instr_pc_o, exp_q[0], cyc);
            end
            checks++;
            if (instr_o !== word_of(exp_q[0])) begin
                errors++;
                $display("FAIL instr: got %h expected %h (cycle %0d)", instr_o, word_of(exp_q[0]), cyc);
            end
        end
        checks++;
        if (fetch_misalign_o !== exp_mis) begin
            errors++;
            $display("FAIL misalign: got %0b expected %0b (cycle %0d)", fetch_misalign_o, exp_mis, cyc);
        end

        exp_mis = 0;
        pop = (occ != 0) && rdy;
        if (pop) begin
            occ--;
            void'(exp_q.pop_front());
            exp_q.push_back(exp_q[$] + 32'd4);
        end
        if (rv) begin
            pending = 0;
            if (pend_epoch == epoch && !redir) occ++;
        end
        if (g) begin
            pending      = 1;
            wait_cnt     = $urandom_range(max_delay, min_delay);
            pend_epoch   = epoch;
            pend_addr    = imem_addr_o;
            exp_req_addr = exp_req_addr + 32'd4;
        end
        if (redir) begin
            epoch++;
            occ = 0;
`ifdef FETCH_MISALIGN_CHK_EN
            if (tgt[1:0] != 2'b00) begin
                halted       = 1;
                exp_mis      = 1;
                exp_req_addr = tgt;
            end else begin
                halted       = 0;
                exp_req_addr = {tgt[31:2], 2'b00};
                model_restart({tgt[31:2], 2'b00});
            end
`else
            exp_req_addr = {tgt[31:2], 2'b00};
            model_restart({tgt[31:2], 2'b00});
`endif
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", instr_valid_o); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr_o); end
        checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", instr_pc_o); end
        checks++; if (fetch_misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %0b expected 0", fetch_misalign_o); end
        checks++; if (state_dbg !== ST_ISSUE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_ISSUE); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_init();
    endtask

    task automatic test_sequential();
        int first_valid = -1;
        logic [31:0] got[$];
        logic [31:0] want[3];
        ready_pct = 100; gnt_pct = 100; min_delay = 0; max_delay = 0;
        want[0] = 32'h0; want[1] = 32'h4; want[2] = 32'h8;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'h0);
            if (instr_valid_o && first_valid < 0) first_valid = i;
            if (instr_valid_o && instr_ready_i) got.push_back(instr_pc_o);
        end
        checks++;
        if (first_valid != 2) begin
            errors++;
            $display("FAIL first_valid_cycle: got %0d expected 2", first_valid);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== want[i]) begin
                errors++;
                $display("FAIL seq_pc%0d: got %h expected %h", i, (got.size() > i) ? got[i] : 32'hx, want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        ready_pct = 0; gnt_pct = 100; min_delay = 0; max_delay = 1;
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0);
        checks++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_full: got req=%0b valid=%0b expected req=0 valid=1", imem_req_o, instr_valid_o);
        end
        ready_pct = 100;
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic test_redirect_outstanding();
        bit found = 0, saw_req = 0, saw_dec = 0;
        ready_pct = 100; gnt_pct = 100; min_delay = 2; max_delay = 2;
        cycle(1'b1, 32'h0);
        for (int i = 0; i < 40 && !found; i++) begin
            if (pending && pend_addr == 32'h8 && wait_cnt > 0) found = 1;
            else cycle(1'b0, 32'h0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redir_setup: got no outstanding request to 00000008 expected one");
        end
        cycle(1'b1, 32'h100);
        min_delay = 0; max_delay = 0;
        for (int i = 0; i < 20 && !(saw_req && saw_dec); i++) begin
            cycle(1'b0, 32'h0);
            if (imem_req_o && !saw_req) begin
                saw_req = 1;
                checks++;
                if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL redir_req_addr: got %h expected 00000100", imem_addr_o); end
            end
            if (instr_valid_o && !saw_dec) begin
                saw_dec = 1;
                checks++;
                if (instr_pc_o !== 32'h100) begin errors++; $display("FAIL redir_dec_pc: got %h expected 00000100", instr_pc_o); end
            end
        end
        checks++;
        if (!(saw_req && saw_dec)) begin
            errors++;
            $display("FAIL redir_timeout: got req=%0b dec=%0b expected both", saw_req, saw_dec);
        end
    endtask

    task automatic test_redirect_full();
        bit found = 0;
        gnt_pct = 100; min_delay = 0; max_delay = 2; ready_pct = 100;
        cycle(1'b1, 32'h200);
        ready_pct = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (occ >= 1 && pending && wait_cnt == 0) found = 1;
            else cycle(1'b0, 32'h0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL flush_setup: got no buffered word with response due expected one");
        end
        ready_pct = 100;
        cycle(1'b1, 32'h300);
        ready_pct = 0;
        cycle(1'b0, 32'h0);
        checks++;
        if (instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %0b expected 0", instr_valid_o);
        end
        ready_pct = 100;
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic test_gnt_stall();
        logic [31:0] a0;
        bit found = 0;
        ready_pct = 100; gnt_pct = 0; min_delay = 0; max_delay = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 32'h0);
            if (imem_req_o) found = 1;
        end
        a0 = imem_addr_o;
        checks++;
        if (!found) begin errors++; $display("FAIL stall_setup: got req=0 expected 1"); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== a0) begin
                errors++;
                $display("FAIL stall_hold: got req=%0b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, a0);
            end
        end
        cycle(1'b1, 32'h40);
        cycle(1'b0, 32'h0);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL stall_redirect: got req=%0b addr=%h expected req=1 addr=00000040", imem_req_o, imem_addr_o);
        end
        gnt_pct = 100;
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        ready_pct = 100; gnt_pct = 100; min_delay = 1; max_delay = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pending && wait_cnt > 0) found = 1;
            else cycle(1'b0, 32'h0);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_setup: got no outstanding request expected one"); end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drive_idle();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_init();
        @(posedge clk);
        #1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        instr_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: got req=%0b addr=%h valid=%0b expected req=1 addr=00000000 valid=0",
                     imem_req_o, imem_addr_o, instr_valid_o);
        end
        min_delay = 0; max_delay = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0);
    endtask

`ifdef FETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        bit saw = 0;
        ready_pct = 100; gnt_pct = 100; min_delay = 0; max_delay = 1;
        cycle(1'b1, 32'h102);
        cycle(1'b0, 32'h0);
        checks++;
        if (fetch_misalign_o !== 1'b1 || imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse: got mis=%0b req=%0b expected mis=1 req=0", fetch_misalign_o, imem_req_o);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0);
            checks++;
            if (fetch_misalign_o !== 1'b0 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL mis_halt: got mis=%0b req=%0b valid=%0b expected 0 0 0", fetch_misalign_o, imem_req_o, instr_valid_o);
            end
        end
        cycle(1'b1, 32'h200);
        for (int i = 0; i < 6 && !saw; i++) begin
            cycle(1'b0, 32'h0);
            if (imem_req_o) begin
                saw = 1;
                checks++;
                if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL mis_resume: got %h expected 00000200", imem_addr_o); end
            end
        end
        checks++;
        if (!saw) begin errors++; $display("FAIL mis_resume_timeout: got req=0 expected 1"); end
    endtask
`endif

    task automatic test_random();
        ready_pct = 70; gnt_pct = 60; min_delay = 0; max_delay = 3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 3) cycle(1'b1, $urandom() & 32'h0000_0FFF);
            else cycle(1'b0, 32'h0);
        end
        ready_pct = 100; gnt_pct = 100;
        cycle(1'b1, 32'h800);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_full();
        test_gnt_stall();
        test_reset_mid();
`ifdef FETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
